// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared definitions for the fetch pipeline controller: FSM states and
// bit positions within the flush and pause vectors.
package fetch_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MISS  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int FL_IF0_1  = 0;
    localparam int FL_IF1_2  = 1;
    localparam int FL_IF2_3  = 2;
    localparam int FL_IF3_IQ = 3;

    localparam int PS_IF0_1 = 0;
    localparam int PS_IF1_2 = 1;
    localparam int PS_IF2_3 = 2;

endpackage

// File: rtl/fetch_stall_counter.sv
// Saturating stall-cycle counter; counts cycles with inc_i high.
// Latency: count visible the cycle after inc_i; no backpressure, holds at all-ones.
module fetch_stall_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch pipeline flush/pause controller; FETCH_CTRL_PERF_EN adds a stall counter.
// Latency: flush/pause combinational from inputs and state; state updates next cycle.
// Backpressure: iq_full or an icache miss pauses IF0..IF3; a flush overrides a pause.
module fetch_pipe_ctrl
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              be_redirect_valid,
    input  logic              be_redirect,
    input  logic              if3_redirect,
    input  logic              icache_miss,
    input  logic              icache_refill_done,
    input  logic              iq_full,
    output logic [3:0]        flush_vec,
    output logic [2:0]        pause_vec,
    output logic              icache_discard,
    output logic [1:0]        state_o,
    output logic [PERF_W-1:0] stall_cnt
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic be_hit;
    logic any_redir;

    assign be_hit    = be_redirect_valid & be_redirect;
    assign any_redir = be_hit | if3_redirect;

    // Backend redirect also kills the IF3/IQ stage; IF3 redirect cannot kill itself.
    always_comb begin
        flush_vec            = '0;
        flush_vec[FL_IF0_1]  = any_redir;
        flush_vec[FL_IF1_2]  = any_redir;
        flush_vec[FL_IF2_3]  = any_redir;
        flush_vec[FL_IF3_IQ] = be_hit;
    end

    always_comb begin
        state_d        = state_q;
        pause_vec      = '0;
        icache_discard = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (icache_miss || iq_full) begin
                    pause_vec = 3'b111;
                end
                if (icache_miss && any_redir) begin
                    state_d = ST_DRAIN;
                end else if (icache_miss) begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS: begin
                pause_vec = 3'b111;
                if (icache_refill_done) begin
                    state_d = ST_RUN;
                end else if (any_redir) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Hold the redirect PC in IF0_1 until the stale refill is swallowed.
                pause_vec[PS_IF0_1] = 1'b1;
                icache_discard      = 1'b1;
                if (icache_refill_done) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic stall_inc;

    assign stall_inc = pause_vec[PS_IF0_1] & ~(|flush_vec);

    fetch_stall_counter #(
        .W(PERF_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl: driver queues expected outputs, monitor compares.
module tb_fetch_pipe_ctrl;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] MISS  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        be_redirect_valid, be_redirect, if3_redirect;
    logic        icache_miss, icache_refill_done, iq_full;
    logic [3:0]  flush_vec;
    logic [2:0]  pause_vec;
    logic        icache_discard;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt;

    fetch_pipe_ctrl #(.PERF_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .be_redirect_valid  (be_redirect_valid),
        .be_redirect        (be_redirect),
        .if3_redirect       (if3_redirect),
        .icache_miss        (icache_miss),
        .icache_refill_done (icache_refill_done),
        .iq_full            (iq_full),
        .flush_vec          (flush_vec),
        .pause_vec          (pause_vec),
        .icache_discard     (icache_discard),
        .state_o            (state_o),
        .stall_cnt          (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fl;
        logic [2:0]  ps;
        logic        dc;
        logic [1:0]  st;
        logic [31:0] sc;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_stall = '0;
`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Monitor: every cycle with an issued vector, compare the whole output set.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (flush_vec !== e.fl || pause_vec !== e.ps || icache_discard !== e.dc ||
                state_o !== e.st || stall_cnt !== e.sc) begin
                n_fail++;
                $display("FAIL %s: got flush=%b pause=%b discard=%b state=%0d stall=%0d, want flush=%b pause=%b discard=%b state=%0d stall=%0d",
                         e.nm, flush_vec, pause_vec, icache_discard, state_o, stall_cnt,
                         e.fl, e.ps, e.dc, e.st, e.sc);
            end
        end
    end

    // One cycle of stimulus: inputs {be_v, be, if3, miss, refill_done, iq_full, rst}.
    task automatic step(input string nm, input logic [6:0] in,
                        input logic [3:0] fl, input logic [2:0] ps,
                        input logic dc, input logic [1:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        {be_redirect_valid, be_redirect, if3_redirect, icache_miss,
         icache_refill_done, iq_full, rst} = in;
        e.fl = fl; e.ps = ps; e.dc = dc; e.st = st; e.sc = exp_stall; e.nm = nm;
        sb.push_back(e);
        if (in[0]) begin
            exp_stall = '0;
        end else if (PERF && ps[0] && fl == 4'b0000 && exp_stall != 32'hFFFF_FFFF) begin
            exp_stall = exp_stall + 32'd1;
        end
    endtask

    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] BE   = 7'b1100000;
    localparam logic [6:0] BEV0 = 7'b0100000;
    localparam logic [6:0] IF3  = 7'b0010000;
    localparam logic [6:0] MS   = 7'b0001000;
    localparam logic [6:0] RD   = 7'b0000100;
    localparam logic [6:0] IQ   = 7'b0000010;
    localparam logic [6:0] RST  = 7'b0000001;

    logic [31:0] s0, s1;

    initial begin
        rst = 1'b1;
        {be_redirect_valid, be_redirect, if3_redirect} = 3'b000;
        {icache_miss, icache_refill_done, iq_full}    = 3'b000;
        repeat (2) @(posedge clk);

        step("reset_state", IDLE, 4'b0000, 3'b000, 1'b0, RUN);

        // Miss with no redirect: refill at cycle 5
        step("miss_c0", MS,   4'b0000, 3'b111, 1'b0, RUN);
        step("miss_c1", IDLE, 4'b0000, 3'b111, 1'b0, MISS);
        step("miss_c2", IDLE, 4'b0000, 3'b111, 1'b0, MISS);
        step("miss_c3", IQ,   4'b0000, 3'b111, 1'b0, MISS);
        step("miss_c4", IDLE, 4'b0000, 3'b111, 1'b0, MISS);
        step("miss_c5", RD,   4'b0000, 3'b111, 1'b0, MISS);
        step("miss_c6", IDLE, 4'b0000, 3'b000, 1'b0, RUN);

        // Redirect during miss
        step("rdm_c0", MS,   4'b0000, 3'b111, 1'b0, RUN);
        step("rdm_c1", IDLE, 4'b0000, 3'b111, 1'b0, MISS);
        step("rdm_c2", IF3,  4'b0111, 3'b111, 1'b0, MISS);
        step("rdm_c3", IDLE, 4'b0000, 3'b001, 1'b1, DRAIN);
        step("rdm_c4", IQ,   4'b0000, 3'b001, 1'b1, DRAIN);
        step("rdm_c5", BE,   4'b1111, 3'b001, 1'b1, DRAIN);
        step("rdm_c6", RD,   4'b0000, 3'b001, 1'b1, DRAIN);
        step("rdm_c7", IDLE, 4'b0000, 3'b000, 1'b0, RUN);

        // Redirect qualifiers and simultaneous redirects in RUN
        step("be_unqualified", BEV0,      4'b0000, 3'b000, 1'b0, RUN);
        step("be_only",        BE,        4'b1111, 3'b000, 1'b0, RUN);
        step("if3_only",       IF3,       4'b0111, 3'b000, 1'b0, RUN);
        step("be_and_if3",     BE | IF3,  4'b1111, 3'b000, 1'b0, RUN);
        step("stray_refill",   RD,        4'b0000, 3'b000, 1'b0, RUN);
        step("after_redirs",   IDLE,      4'b0000, 3'b000, 1'b0, RUN);

        // Redirect coinciding with refill in MISS wins back to RUN
        step("rdref_c0", MS,       4'b0000, 3'b111, 1'b0, RUN);
        step("rdref_c1", IF3 | RD, 4'b0111, 3'b111, 1'b0, MISS);
        step("rdref_c2", IDLE,     4'b0000, 3'b000, 1'b0, RUN);
        step("rdref_c3", MS,       4'b0000, 3'b111, 1'b0, RUN);
        step("rdref_c4", BE | RD,  4'b1111, 3'b111, 1'b0, MISS);
        step("rdref_c5", IDLE,     4'b0000, 3'b000, 1'b0, RUN);

        // Miss with backend redirect in RUN goes straight to DRAIN
        step("missbe_c0", MS | BE, 4'b1111, 3'b111, 1'b0, RUN);
        step("missbe_c1", RD,      4'b0000, 3'b001, 1'b1, DRAIN);
        step("missbe_c2", IDLE,    4'b0000, 3'b000, 1'b0, RUN);

        // IQ backpressure for 3 cycles
        s0 = stall_cnt;
        step("iq_c0", IQ,   4'b0000, 3'b111, 1'b0, RUN);
        step("iq_c1", IQ,   4'b0000, 3'b111, 1'b0, RUN);
        step("iq_c2", IQ,   4'b0000, 3'b111, 1'b0, RUN);
        step("iq_c3", IDLE, 4'b0000, 3'b000, 1'b0, RUN);
        s1 = stall_cnt;
        n_checks++;
        if ((s1 - s0) !== (PERF ? 32'd3 : 32'd0)) begin
            n_fail++;
            $display("FAIL iq_stall_delta: got %0d, want %0d", s1 - s0, PERF ? 3 : 0);
        end

        // Reset while in DRAIN; a later refill pulse is ignored
        step("rstd_c0", MS | IF3, 4'b0111, 3'b111, 1'b0, RUN);
        step("rstd_c1", IDLE,     4'b0000, 3'b001, 1'b1, DRAIN);
        step("rstd_c2", RST,      4'b0000, 3'b001, 1'b1, DRAIN);
        step("rstd_c3", IDLE,     4'b0000, 3'b000, 1'b0, RUN);
        step("rstd_c4", IDLE,     4'b0000, 3'b000, 1'b0, RUN);
        step("rstd_c5", RD,       4'b0000, 3'b000, 1'b0, RUN);
        step("rstd_c6", IDLE,     4'b0000, 3'b000, 1'b0, RUN);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
